counter: RTL and testbench
==========================

Name: counter

Overview:
- Parameterised free-running up-counter with enable, programmable start value, exclusive terminal value and step size.
- Used as a generic building block, e.g. for address generation, timing and sequencing.
- One clock domain; synchronous active-low reset; registered output.

Parameters:
- ARCHITECTURE, "BEHAVIORAL", implementation selector. Only "BEHAVIORAL" is supported; any other value is an elaboration error.
- DATA_WIDTH, 8, width of out in bits; must be >= 1.
- COUNT_FROM, 0, value loaded on reset and on wrap; 0 <= COUNT_FROM < COUNT_TO.
- COUNT_TO, 2**DATA_WIDTH, exclusive upper bound; out never equals or exceeds it; COUNT_TO <= 2**DATA_WIDTH.
- STEP, 1, increment per enabled cycle; 1 <= STEP <= COUNT_TO - COUNT_FROM.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst=0 resets)
- en  input  1  count enable, active-high
- out  output  DATA_WIDTH  current count, registered

Behaviour:
- All state changes on the rising edge of clk only.
- Reset: if rst=0 at a rising edge, out <= COUNT_FROM. Reset has priority over en.
  - Reset mid-count discards the current value.
  - out is undefined before the first clock edge with rst=0.
  - A design held in reset stays at COUNT_FROM regardless of en.
- Hold: if rst=1 and en=0, out keeps its value.
- Count: if rst=1 and en=1:
  - Form next = out + STEP in at least DATA_WIDTH+1 bits (32-bit integer arithmetic is acceptable), so there is no silent truncation.
  - If next >= COUNT_TO, out <= COUNT_FROM (wrap). Otherwise out <= next[DATA_WIDTH-1:0].
- Wrap restarts exactly at COUNT_FROM. Any overshoot from a STEP that does not divide the range evenly is discarded, with no remainder carry.
- Latency: out reflects a reset or enabled step one clock after the sampling edge. There is no combinational path from en or rst to out.
- Period with en continuously high equals ceil((COUNT_TO - COUNT_FROM)/STEP) cycles.
- Defaults count 0..255 and wrap to 0.
- COUNT_TO = 2**DATA_WIDTH must work without overflowing the comparison.
- Elaboration-time checks (generate-time $error or equivalent) apply to every parameter constraint above.
- No X propagation from en when rst=0.

Decomposition:
- Shared package counter_pkg holds:
  - the ARCHITECTURE string constant "BEHAVIORAL";
  - a function computing the comparison width, max(DATA_WIDTH+1, clog2(COUNT_TO)+1);
  - the parameter-legality check function.
- One natural combinational sub-module, counter_next, computes the next value and the wrap flag from out, STEP, COUNT_FROM and COUNT_TO.
- The top level holds the register, the reset/enable priority logic and the ARCHITECTURE generate selection.

Test Plan:
- DATA_WIDTH=8, COUNT_FROM=20, COUNT_TO=256, STEP=1:
  - Hold rst=0 for 3 clocks with en=1 -> out=20 on every edge.
  - Release rst=1 with en=1 -> out reads 21, 22, ... on successive edges. After 235 enabled edges out=255; the next edge gives out=20.
- Same configuration: count to 50, drop en for 5 clocks -> out stays 50, then resumes at 51 when en=1.
- Same configuration: at out=100 assert rst=0 together with en=1 -> out=20 on that edge. Reset wins.
- Defaults (0, 256, step 1): 256 enabled cycles from reset -> out sequence 0..255 then 0. No value outside 0..255.
- DATA_WIDTH=4, COUNT_FROM=1, COUNT_TO=10, STEP=3 -> sequence 1, 4, 7, 1, 4, ... (7+3=10 >= 10 wraps to 1).
- Illegal parameters (COUNT_FROM=10, COUNT_TO=5, or ARCHITECTURE="FOO") -> elaboration fails.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised up-counter.
// Everything here is evaluated at elaboration; nothing generates hardware.
package counter_pkg;

    localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";

    // COUNT_TO is carried as a 32-bit int, so 2**DATA_WIDTH must stay representable.
    localparam int MAX_DATA_WIDTH = 30;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width wide enough to hold out + STEP and COUNT_TO without truncation.
    function automatic int cmp_width(input int data_width, input int count_to);
        int w_data;
        int w_to;
        w_data = data_width + 1;
        w_to   = (count_to > 1) ? ($clog2(count_to) + 1) : 2;
        return max_int(w_data, w_to);
    endfunction

    function automatic bit params_legal(
        input int data_width,
        input int count_from,
        input int count_to,
        input int step
    );
        longint range_top;
        if (data_width < 1 || data_width > MAX_DATA_WIDTH) begin
            return 1'b0;
        end
        range_top = longint'(1) << data_width;
        if (count_from < 0)                         return 1'b0;
        if (count_from >= count_to)                 return 1'b0;
        if (longint'(count_to) > range_top)         return 1'b0;
        if (step < 1)                               return 1'b0;
        if (step > (count_to - count_from))         return 1'b0;
        return 1'b1;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-value logic: adds STEP in a widened domain and
// restarts at COUNT_FROM once the sum reaches the exclusive bound.
module counter_next
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COUNT_FROM = 0,
    parameter int COUNT_TO   = 256,
    parameter int STEP       = 1,
    parameter int CMP_W      = 9
) (
    input  logic [DATA_WIDTH-1:0] cur_i,
    output logic [DATA_WIDTH-1:0] next_o,
    output logic                  wrap_o
);

    localparam logic [CMP_W-1:0]      STEP_W = CMP_W'(STEP);
    localparam logic [CMP_W-1:0]      TO_W   = CMP_W'(COUNT_TO);
    localparam logic [DATA_WIDTH-1:0] FROM_D = DATA_WIDTH'(COUNT_FROM);

    logic [CMP_W-1:0] sum;

    // Overshoot past COUNT_TO is dropped: wrap lands exactly on COUNT_FROM.
    always_comb begin
        sum    = CMP_W'(cur_i) + STEP_W;
        wrap_o = (sum >= TO_W);
        next_o = wrap_o ? FROM_D : sum[DATA_WIDTH-1:0];
    end

endmodule : counter_next

// File: rtl/counter.sv
// Free-running up-counter with enable, programmable start, exclusive terminal
// value and step. Reset (active-low, synchronous) takes priority over enable.
module counter
    import counter_pkg::*;
#(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    DATA_WIDTH   = 8,
    parameter int    COUNT_FROM   = 0,
    parameter int    COUNT_TO     = 2 ** DATA_WIDTH,
    parameter int    STEP         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int CMP_W = cmp_width(DATA_WIDTH, COUNT_TO);

    if (!params_legal(DATA_WIDTH, COUNT_FROM, COUNT_TO, STEP)) begin : g_bad_params
        $error("counter: illegal parameters DATA_WIDTH=%0d COUNT_FROM=%0d COUNT_TO=%0d STEP=%0d",
               DATA_WIDTH, COUNT_FROM, COUNT_TO, STEP);
    end

    if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral
        localparam logic [DATA_WIDTH-1:0] FROM_D = DATA_WIDTH'(COUNT_FROM);

        logic [DATA_WIDTH-1:0] count_q;
        logic [DATA_WIDTH-1:0] count_d;
        logic [DATA_WIDTH-1:0] step_val;
        logic                  wrap;

        counter_next #(
            .DATA_WIDTH (DATA_WIDTH),
            .COUNT_FROM (COUNT_FROM),
            .COUNT_TO   (COUNT_TO),
            .STEP       (STEP),
            .CMP_W      (CMP_W)
        ) u_next (
            .cur_i  (count_q),
            .next_o (step_val),
            .wrap_o (wrap)
        );

        always_comb begin
            count_d = en ? step_val : count_q;
        end

        // Reset is checked first so an X on en cannot leak into the count.
        always_ff @(posedge clk) begin
            if (!rst) begin
                count_q <= FROM_D;
            end else begin
                count_q <= count_d;
            end
        end

        assign out = count_q;
    end else begin : g_unsupported
        $error("counter: unsupported ARCHITECTURE \"%s\"", ARCHITECTURE);
        assign out = '0;
    end

endmodule : counter

// File: tb/tb_counter.sv
// Directed bench for counter: three configurations (offset start, defaults,
// non-dividing step) driven from vector tables and hand-written sequences.
module tb_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, en_a = 1'b0;
    logic       rst_d = 1'b0, en_d = 1'b0;
    logic       rst_b = 1'b0, en_b = 1'b0;
    logic [7:0] out_a;
    logic [7:0] out_d;
    logic [3:0] out_b;

    int tests  = 0;
    int failed = 0;

    counter #(
        .ARCHITECTURE ("BEHAVIORAL"),
        .DATA_WIDTH   (8),
        .COUNT_FROM   (20),
        .COUNT_TO     (256),
        .STEP         (1)
    ) u_a (
        .clk (clk),
        .rst (rst_a),
        .en  (en_a),
        .out (out_a)
    );

    counter u_d (
        .clk (clk),
        .rst (rst_d),
        .en  (en_d),
        .out (out_d)
    );

    counter #(
        .DATA_WIDTH (4),
        .COUNT_FROM (1),
        .COUNT_TO   (10),
        .STEP       (3)
    ) u_b (
        .clk (clk),
        .rst (rst_b),
        .en  (en_b),
        .out (out_b)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] exp;
    } vec_t;

    vec_t vec_a[12];
    vec_t vec_b[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sel: 0 = offset-start DUT, 1 = default DUT, 2 = step-3 DUT
    task automatic drive(input int sel, input logic r, input logic e);
        @(negedge clk);
        case (sel)
            0: begin rst_a = r; en_a = e; end
            1: begin rst_d = r; en_d = e; end
            default: begin rst_b = r; en_b = e; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_a = '{
            '{1'b0, 1'b1, 8'd20}, '{1'b0, 1'b1, 8'd20}, '{1'b0, 1'b1, 8'd20},
            '{1'b1, 1'b1, 8'd21}, '{1'b1, 1'b1, 8'd22}, '{1'b1, 1'b1, 8'd23},
            '{1'b1, 1'b0, 8'd23}, '{1'b1, 1'b0, 8'd23},
            '{1'b0, 1'b0, 8'd20},
            '{1'b1, 1'b1, 8'd21}, '{1'b1, 1'b1, 8'd22}, '{1'b0, 1'b1, 8'd20}
        };
        vec_b = '{
            '{1'b0, 1'b1, 8'd1}, '{1'b0, 1'b0, 8'd1},
            '{1'b1, 1'b1, 8'd4}, '{1'b1, 1'b1, 8'd7}, '{1'b1, 1'b1, 8'd1},
            '{1'b1, 1'b1, 8'd4}, '{1'b1, 1'b1, 8'd7}, '{1'b1, 1'b0, 8'd7},
            '{1'b1, 1'b1, 8'd1}, '{1'b1, 1'b1, 8'd4},
            '{1'b0, 1'b1, 8'd1}, '{1'b1, 1'b1, 8'd4}, '{1'b1, 1'b1, 8'd7},
            '{1'b1, 1'b1, 8'd1}
        };

        // Offset-start configuration: table first.
        for (int i = 0; i < 12; i++) begin
            drive(0, vec_a[i].rst, vec_a[i].en);
            check($sformatf("a_vec[%0d]", i), out_a, vec_a[i].exp);
        end

        // From 20: count up to 50, hold 5 cycles, resume at 51.
        for (int v = 21; v <= 50; v++) begin
            drive(0, 1'b1, 1'b1);
            check("a_to50", out_a, 8'(v));
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 1'b0);
            check("a_hold50", out_a, 8'd50);
        end
        drive(0, 1'b1, 1'b1);
        check("a_resume51", out_a, 8'd51);

        // Count on to 100, then reset together with en: reset wins.
        for (int v = 52; v <= 100; v++) begin
            drive(0, 1'b1, 1'b1);
        end
        check("a_at100", out_a, 8'd100);
        drive(0, 1'b0, 1'b1);
        check("a_rst_at100", out_a, 8'd20);

        // Full period: 235 enabled edges reach 255, the next wraps to 20.
        for (int i = 1; i <= 235; i++) begin
            drive(0, 1'b1, 1'b1);
            check("a_full", out_a, 8'(20 + i));
        end
        drive(0, 1'b1, 1'b1);
        check("a_wrap", out_a, 8'd20);
        drive(0, 1'b1, 1'b1);
        check("a_after_wrap", out_a, 8'd21);

        // Defaults: reset to 0, then 0..255 and back to 0.
        drive(1, 1'b0, 1'b1);
        check("d_reset", out_d, 8'd0);
        for (int i = 1; i <= 256; i++) begin
            drive(1, 1'b1, 1'b1);
            check("d_seq", out_d, (i == 256) ? 8'd0 : 8'(i));
        end

        // Step 3 over [1,10): 1, 4, 7, 1, ...
        for (int i = 0; i < 14; i++) begin
            drive(2, vec_b[i].rst, vec_b[i].en);
            check($sformatf("b_vec[%0d]", i), {4'b0, out_b}, vec_b[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_counter
